// File: rtl/can_bitstream_driver_pkg.sv
// Shared types and constants for the CAN bit-stream driver.
package can_drv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StTx,
    StIfs
  } drv_state_e;

  // Shortest legal bit period in clocks.
  localparam int unsigned MIN_BIT_LEN = 4;
  // Identical consecutive bits before a stuff bit is owed.
  localparam int unsigned STUFF_RUN = 5;

endpackage

// File: rtl/can_bitstream_driver_if.sv
// Frame handshake, bit-timing config and serial outputs of the CAN bit-stream driver.
interface can_bitstream_driver_if #(
  parameter int unsigned MAX_BITS = 128,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LEN_W    = $clog2(MAX_BITS + 1)
);

  logic [CNT_W-1:0]    cfg_bit_len;
  logic [CNT_W-1:0]    cfg_sample_pos;
  logic                frame_valid;
  logic                frame_ready;
  logic [MAX_BITS-1:0] frame_bits;
  logic [LEN_W-1:0]    frame_len;
  logic                stuff_en;
  logic                abort;
  logic                tx_bit;
  logic                sample_point;
  logic                bit_start;
  logic                stuff_flag;
  logic                busy;
  logic                done;

  // Frame source / bus observer side.
  modport master (
    output cfg_bit_len, cfg_sample_pos, frame_valid, frame_bits, frame_len, stuff_en, abort,
    input  frame_ready, tx_bit, sample_point, bit_start, stuff_flag, busy, done
  );

  // Driver side.
  modport slave (
    input  cfg_bit_len, cfg_sample_pos, frame_valid, frame_bits, frame_len, stuff_en, abort,
    output frame_ready, tx_bit, sample_point, bit_start, stuff_flag, busy, done
  );

endinterface

// File: rtl/can_bitstream_driver_bit_timer.sv
// Free-running time-quantum counter with clamped, per-bit latched period and sample position.
module can_bit_timer
  import can_drv_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_bit_len,
  input  logic [CNT_W-1:0] cfg_sample_pos,
  output logic             bit_start,
  output logic             sample_point,
  // High when the coming clock edge starts a new bit; lets the FSM register bit data in step.
  output logic             bit_start_next
);

  localparam logic [CNT_W-1:0] MinLen = CNT_W'(MIN_BIT_LEN);

  logic [CNT_W-1:0] tq_q, len_q, spos_q;
  logic [CNT_W-1:0] tq_d, len_new, spos_new, spos_eff;
  logic             wrap;
  logic             bit_start_q, sample_point_q;

  // Clamp the incoming config and compute the next counter value.
  always_comb begin
    len_new  = (cfg_bit_len < MinLen) ? MinLen : cfg_bit_len;
    spos_new = (cfg_sample_pos > (len_new - CNT_W'(1))) ? (len_new - CNT_W'(1)) : cfg_sample_pos;
    wrap     = (tq_q >= (len_q - CNT_W'(1)));
    tq_d     = wrap ? '0 : (tq_q + CNT_W'(1));
    // A new sample position only takes effect from the bit that starts at the wrap.
    spos_eff = wrap ? spos_new : spos_q;
  end

  assign bit_start_next = (tq_d == '0);

  // Counter, latched timing and registered pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tq_q           <= '0;
      len_q          <= len_new;
      spos_q         <= spos_new;
      bit_start_q    <= 1'b0;
      sample_point_q <= 1'b0;
    end else begin
      tq_q           <= tq_d;
      bit_start_q    <= bit_start_next;
      sample_point_q <= (tq_d == spos_eff);
      if (wrap) begin
        len_q  <= len_new;
        spos_q <= spos_new;
      end
    end
  end

  assign bit_start    = bit_start_q;
  assign sample_point = sample_point_q;

endmodule

// File: rtl/can_bitstream_driver.sv
// CAN bit-stream driver: serialises a frame MSB-first with optional stuffing, abort and IFS.
module can_bitstream_driver
  import can_drv_pkg::*;
#(
  parameter int unsigned MAX_BITS = 128,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned IFS_BITS = 3
) (
  input logic                   clk,
  input logic                   rst,
  can_bitstream_driver_if.slave bus
);

  localparam int unsigned LEN_W = $clog2(MAX_BITS + 1);
  localparam int unsigned IFS_W = (IFS_BITS > 2) ? $clog2(IFS_BITS) : 1;
  localparam int unsigned RUN_W = 3;
  localparam int unsigned MSB   = MAX_BITS - 1;

  localparam logic [RUN_W-1:0] RunMax  = RUN_W'(STUFF_RUN);
  localparam logic [IFS_W-1:0] IfsLast = IFS_W'(IFS_BITS - 1);

  drv_state_e          state_q;
  logic [MAX_BITS-1:0] shreg_q;
  logic [LEN_W-1:0]    left_q;
  logic [RUN_W-1:0]    run_q;
  logic                last_q;
  logic                stuff_q;
  logic                abort_pend_q;
  logic [IFS_W-1:0]    ifs_cnt_q;
  logic                tx_bit_q, stuff_flag_q, busy_q, done_q;

  logic                bit_start, sample_point, bit_start_next;
  logic                frame_ready;
  logic [LEN_W-1:0]    len_c;
  logic [MAX_BITS-1:0] aligned;
  logic                accept, abort_now, stuff_due, data_bit;

  can_bit_timer #(
    .CNT_W (CNT_W)
  ) u_bit_timer (
    .clk            (clk),
    .rst            (rst),
    .cfg_bit_len    (bus.cfg_bit_len),
    .cfg_sample_pos (bus.cfg_sample_pos),
    .bit_start      (bit_start),
    .sample_point   (sample_point),
    .bit_start_next (bit_start_next)
  );

  assign frame_ready = (state_q == StIdle) && rst;

  // Handshake decode; the frame is left-aligned so the first bit always sits at the MSB.
  always_comb begin
    len_c     = (bus.frame_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : bus.frame_len;
    aligned   = bus.frame_bits << (LEN_W'(MAX_BITS) - len_c);
    accept    = bus.frame_valid && frame_ready;
    abort_now = abort_pend_q || bus.abort;
    stuff_due = stuff_q && (run_q == RunMax);
    data_bit  = shreg_q[MSB];
  end

  // Frame FSM with registered serial outputs; all bit-level actions happen on a bit_start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      left_q       <= '0;
      run_q        <= '0;
      last_q       <= 1'b1;
      stuff_q      <= 1'b0;
      abort_pend_q <= 1'b0;
      ifs_cnt_q    <= '0;
      tx_bit_q     <= 1'b1;
      stuff_flag_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort && ((state_q == StArmed) || (state_q == StTx))) begin
        abort_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_q <= aligned;
            left_q  <= len_c;
            stuff_q <= bus.stuff_en;
            run_q   <= '0;
            if (len_c == '0) begin
              done_q <= 1'b1;
            end else if (bit_start_next) begin
              // Accepted right at a wrap: first bit goes out on this bit_start.
              state_q  <= StTx;
              busy_q   <= 1'b1;
              tx_bit_q <= aligned[MSB];
              last_q   <= aligned[MSB];
              shreg_q  <= aligned << 1;
              left_q   <= len_c - LEN_W'(1);
              run_q    <= RUN_W'(1);
            end else begin
              state_q <= StArmed;
              busy_q  <= 1'b1;
            end
          end
        end
        StArmed: begin
          if (bit_start_next) begin
            if (abort_now) begin
              state_q      <= StIfs;
              tx_bit_q     <= 1'b1;
              stuff_flag_q <= 1'b0;
              done_q       <= 1'b1;
              ifs_cnt_q    <= '0;
              abort_pend_q <= 1'b0;
            end else begin
              state_q  <= StTx;
              tx_bit_q <= data_bit;
              last_q   <= data_bit;
              shreg_q  <= shreg_q << 1;
              left_q   <= left_q - LEN_W'(1);
              run_q    <= RUN_W'(1);
            end
          end
        end
        StTx: begin
          if (bit_start_next) begin
            if (abort_now || (!stuff_due && (left_q == '0))) begin
              // Abort wins over a coincident natural end, giving one done pulse.
              state_q      <= StIfs;
              tx_bit_q     <= 1'b1;
              stuff_flag_q <= 1'b0;
              done_q       <= 1'b1;
              ifs_cnt_q    <= '0;
              abort_pend_q <= 1'b0;
            end else if (stuff_due) begin
              // Stuff bit: complement, data index holds, starts a fresh run.
              tx_bit_q     <= ~last_q;
              last_q       <= ~last_q;
              stuff_flag_q <= 1'b1;
              run_q        <= RUN_W'(1);
            end else begin
              tx_bit_q     <= data_bit;
              last_q       <= data_bit;
              stuff_flag_q <= 1'b0;
              shreg_q      <= shreg_q << 1;
              left_q       <= left_q - LEN_W'(1);
              if (data_bit != last_q) begin
                run_q <= RUN_W'(1);
              end else if (run_q != RunMax) begin
                run_q <= run_q + RUN_W'(1);
              end
            end
          end
        end
        StIfs: begin
          if (bit_start_next) begin
            if (ifs_cnt_q == IfsLast) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              ifs_cnt_q <= ifs_cnt_q + IFS_W'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.frame_ready  = frame_ready;
  assign bus.tx_bit       = tx_bit_q;
  assign bus.stuff_flag   = stuff_flag_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.bit_start    = bit_start;
  assign bus.sample_point = sample_point;

endmodule
